// File: rtl/load_store_unit.sv
// load_store_unit
//   RV32I load/store sequencer between the execute stage and a word-wide dataMem.
//   Loads LB/LH/LW/LBU/LHU are lane-selected and sign/zero-extended; stores SW go
//   straight to WR, SB/SH do a read-modify-write (RD then WR) because dataMem only
//   writes whole words. Each request is a multi-cycle req/done transaction.
//
//   Optional feature macro: MISALIGN_TRAP_EN
//     defined   : misaligned H/W and illegal funct3 end in DONE with fault=1
//     undefined : fault tied 0, misaligned low address bits are aligned down
//
// Ports
//   clk, reset        rising-edge clock, async active-high reset
//   req/we/funct3     request strobe (sampled in IDLE only), store flag, width code
//   addr/wdata        byte address, store data
//   busy/done         transaction in progress / one-cycle completion pulse
//   rdata/fault       extended load result and fault flag, valid with done
//   mem_write/mem_addr/mem_din/mem_dout   dataMem interface (mem_dout combinational)
module load_store_unit #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req,
  input  logic                  we,
  input  logic [2:0]            funct3,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  output logic                  busy,
  output logic                  done,
  output logic [31:0]           rdata,
  output logic                  fault,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_din,
  input  logic [31:0]           mem_dout
);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  typedef struct packed {
    logic                  we;
    logic [2:0]            f3;
    logic [ADDR_WIDTH-1:0] addr;
    logic [31:0]           wdata;
  } lsu_req_t;

  state_t   state, state_nxt;
  lsu_req_t r;
  logic [31:0] word;

  // Request classification on the live inputs (used only when sampled in IDLE)
  logic illegal, misalign, bad;
  assign illegal  = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111) ||
                    (funct3[2] && we);
  assign misalign = ((funct3[1:0] == 2'b01) && addr[0]) ||
                    ((funct3 == 3'b010) && (addr[1:0] != 2'b00));
`ifdef MISALIGN_TRAP_EN
  assign bad = illegal || misalign;
`else
  // Misaligned accesses just fall through; lane logic ignores the low bits.
  assign bad = illegal;
`endif

  // Load extraction: byte lane from addr[1:0], half lane from addr[1]
  function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] a,
                                           input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{a, 3'b000} +: 8];
    h = a[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  load_ext = {{24{b[7]}}, b};
      3'b001:  load_ext = {{16{h[15]}}, h};
      3'b100:  load_ext = {24'b0, b};
      3'b101:  load_ext = {16'b0, h};
      default: load_ext = w;
    endcase
  endfunction

  // Next-state / output decode
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (req) begin
              if (bad)                         state_nxt = DONE;
              else if (we && funct3 == 3'b010) state_nxt = WR;
              else                             state_nxt = RD;
            end
      RD:   state_nxt = r.we ? WR : DONE;
      WR:   state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  // Decoded from the state register so reset kills the write immediately.
  assign mem_write = (state == WR);
  assign mem_addr  = {r.addr[ADDR_WIDTH-1:2], 2'b00};

  // Store data: SW passes through, SB/SH splice into the word read in RD
  always_comb begin
    mem_din = word;
    if (r.f3 == 3'b010)
      mem_din = r.wdata;
    else if (r.f3[1:0] == 2'b00)
      mem_din[{r.addr[1:0], 3'b000} +: 8] = r.wdata[7:0];
    else
      mem_din[{r.addr[1], 4'b0000} +: 16] = r.wdata[15:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      r     <= '0;
      word  <= '0;
      rdata <= '0;
      fault <= 1'b0;
    end else begin
      state <= state_nxt;
      unique case (state)
        IDLE: if (req) begin
                r <= '{we: we, f3: funct3, addr: addr, wdata: wdata};
                if (bad) begin
                  rdata <= '0;
`ifdef MISALIGN_TRAP_EN
                  fault <= 1'b1;
`else
                  fault <= 1'b0;
`endif
                end
              end
        RD: begin
              word <= mem_dout;
              // Result registered on the way into DONE so it is valid with done
              if (!r.we) begin
                rdata <= load_ext(r.f3, r.addr[1:0], mem_dout);
                fault <= 1'b0;
              end
            end
        WR: begin
              rdata <= '0;
              fault <= 1'b0;
            end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;
  logic        clk = 1'b0;
  logic        reset, req, we;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic        busy, done, fault, mem_write;
  logic [31:0] rdata, mem_addr, mem_din, mem_dout;

  load_store_unit #(.ADDR_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .funct3(funct3), .addr(addr),
    .wdata(wdata), .busy(busy), .done(done), .rdata(rdata), .fault(fault),
    .mem_write(mem_write), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  // dataMem: combinational read, word write on the clock edge
  logic [31:0] mem [16];
  logic [31:0] ref_mem [16];
  int          wr_cnt = 0;
  logic [31:0] last_din = '0, last_maddr = '0;
  assign mem_dout = mem[mem_addr[5:2]];
  always @(posedge clk) if (mem_write) begin
    mem[mem_addr[5:2]] <= mem_din;
    wr_cnt     <= wr_cnt + 1;
    last_din   <= mem_din;
    last_maddr <= mem_addr;
  end

  int checks = 0, errors = 0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: RV32I load/store semantics on a word array
  task automatic ref_op(input logic w, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, output logic [31:0] e_rd,
                        output logic e_flt, output int e_lat, output int e_wr);
    int unsigned off, idx;
    logic [31:0] wv, mask;
    logic [7:0]  b;
    logic [15:0] h;
    logic ill, mis, trap;
    off  = a[1:0];
    idx  = a[5:2];
    wv   = ref_mem[idx];
    ill  = (f3 == 3) || (f3 == 6) || (f3 == 7) || (f3[2] && w);
    mis  = (f3[1:0] == 2'b01 && off[0]) || (f3 == 3'd2 && off != 0);
`ifdef MISALIGN_TRAP_EN
    trap = ill || mis;
    e_flt = trap;
`else
    trap = ill;
    e_flt = 1'b0;
`endif
    e_rd = 0; e_lat = 1; e_wr = 0;
    if (trap) return;
    if (f3[1:0] == 2'b01) off = off & 2;
    if (f3 == 3'd2) off = 0;
    b = 8'(wv >> (8 * off));
    h = 16'(wv >> (8 * off));
    if (!w) begin
      e_lat = 2;
      case (f3)
        3'd0: e_rd = 32'($signed(b));
        3'd1: e_rd = 32'($signed(h));
        3'd4: e_rd = {24'b0, b};
        3'd5: e_rd = {16'b0, h};
        default: e_rd = wv;
      endcase
    end else if (f3 == 3'd2) begin
      ref_mem[idx] = wd; e_lat = 2; e_wr = 1;
    end else begin
      mask = ((f3 == 3'd0) ? 32'hFF : 32'hFFFF) << (8 * off);
      ref_mem[idx] = (wv & ~mask) | ((wd << (8 * off)) & mask);
      e_lat = 3; e_wr = 1;
    end
  endtask

  // Drive one transaction; optionally pulse a stray req while busy
  task automatic do_op(input logic w, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input bit noise, output logic [31:0] o_rd,
                       output logic o_flt, output int lat, output int wrs);
    int w0;
    bit seen;
    @(negedge clk);
    req = 1; we = w; funct3 = f3; addr = a; wdata = wd;
    w0 = wr_cnt; lat = 0; seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      lat++;
      req = 0;
      if (done) begin seen = 1; break; end
      if (noise && lat == 1) begin
        req = 1; we = 1; funct3 = 3'd2; addr = $urandom_range(0, 63); wdata = $urandom;
      end
    end
    chk("done_seen", 32'(seen), 32'd1);
    o_rd = rdata; o_flt = fault; wrs = wr_cnt - w0;
    @(posedge clk); #1;
    chk("busy_after_done", 32'(busy), 32'd0);
  endtask

  logic [31:0] g_rd;
  task automatic run(input string tag, input logic w, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] wd, input bit noise);
    logic [31:0] e_rd; logic e_flt, o_flt; int e_lat, e_wr, lat, wrs;
    ref_op(w, f3, a, wd, e_rd, e_flt, e_lat, e_wr);
    do_op(w, f3, a, wd, noise, g_rd, o_flt, lat, wrs);
    chk({tag, ".rdata"}, g_rd, e_rd);
    chk({tag, ".fault"}, 32'(o_flt), 32'(e_flt));
    chk({tag, ".latency"}, 32'(lat), 32'(e_lat));
    chk({tag, ".writes"}, 32'(wrs), 32'(e_wr));
  endtask

  initial begin
    int quiet;
    for (int i = 0; i < 16; i++) begin mem[i] = 0; ref_mem[i] = 0; end
    reset = 1; req = 0; we = 0; funct3 = 0; addr = 0; wdata = 0;
    #12;
    chk("rst.busy", 32'(busy), 0);
    chk("rst.done", 32'(done), 0);
    chk("rst.rdata", rdata, 0);
    chk("rst.fault", 32'(fault), 0);
    chk("rst.mem_write", 32'(mem_write), 0);
    chk("rst.mem_addr", mem_addr, 0);
    chk("rst.mem_din", mem_din, 0);
    @(negedge clk); reset = 0;

    run("init_sw", 1, 3'd2, 32'h0, 32'hDEADBEEF, 0);
    run("t1_sw", 1, 3'd2, 32'h4, 32'h12345678, 0);
    chk("t1.mem_din", last_din, 32'h12345678);
    chk("t1.mem_addr", last_maddr, 32'h4);
    run("t2_sb", 1, 3'd0, 32'h5, 32'h000000AB, 0);
    chk("t2.mem_din", last_din, 32'h1234AB78);
    run("t2_lw", 0, 3'd2, 32'h4, 0, 0);
    chk("t2.lw", g_rd, 32'h1234AB78);
    run("t3_lb", 0, 3'd0, 32'h5, 0, 0);  chk("t3.lb", g_rd, 32'hFFFFFFAB);
    run("t3_lbu", 0, 3'd4, 32'h5, 0, 0); chk("t3.lbu", g_rd, 32'h000000AB);
    run("t3_lh", 0, 3'd1, 32'h6, 0, 0);  chk("t3.lh", g_rd, 32'h00001234);
    run("t3_lhu", 0, 3'd5, 32'h4, 0, 0); chk("t3.lhu", g_rd, 32'h0000AB78);
    run("t4_sh", 1, 3'd1, 32'h2, 32'hFFFF8001, 0);
    chk("t4.mem_din", last_din, 32'h8001BEEF);
    run("t4_lh", 0, 3'd1, 32'h2, 0, 0);  chk("t4.lh", g_rd, 32'hFFFF8001);
    run("t5_lw_mis", 0, 3'd2, 32'h6, 0, 0);
`ifdef MISALIGN_TRAP_EN
    chk("t5.lw", g_rd, 32'h0);
`else
    chk("t5.lw", g_rd, 32'h1234AB78);
`endif
    run("illegal_sbu", 1, 3'd4, 32'h8, 32'h1, 0);

    // Reset while WR is presented: no write may land
    @(negedge clk);
    req = 1; we = 1; funct3 = 3'd0; addr = 0; wdata = 32'h55;
    @(posedge clk); #1; req = 0;
    @(posedge clk); #1;
    chk("t6.mem_write_in_wr", 32'(mem_write), 1);
    reset = 1; #1;
    chk("t6.mem_write_drop", 32'(mem_write), 0);
    chk("t6.busy", 32'(busy), 0);
    chk("t6.done", 32'(done), 0);
    @(negedge clk); reset = 0;
    quiet = 0;
    for (int i = 0; i < 4; i++) begin @(posedge clk); #1; if (done) quiet++; end
    chk("t6.no_done", 32'(quiet), 0);
    run("t6_lw", 0, 3'd2, 32'h0, 0, 0);
    chk("t6.lw", g_rd, 32'h8001BEEF);

    for (int n = 0; n < 300; n++)
      run("rand", 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
          32'($urandom_range(0, 63)), $urandom, 1'($urandom_range(0, 1)));

    for (int i = 0; i < 16; i++) chk($sformatf("mem[%0d]", i), mem[i], ref_mem[i]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
